// File: rtl/cmp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cmp_seq_ctrl
//
// Sequential magnitude-compare controller. It scans two WIDTH-bit operands
// two bits per clock, starting with the most significant pair. All pairs go
// through one 2-bit comparator slice, and the scan stops at the first unequal
// pair.
//
// Ports:
//   clk     - single clock; every register updates on the rising edge
//   rst     - synchronous, active-high reset
//   start   - compare request; accepted only in IDLE or DONE
//   A, B    - operands; captured on the accepted-start edge only
//   busy    - high while the scan is in progress
//   done    - one-cycle pulse when gt/eq/lt/npairs are valid
//   gt/eq/lt- one-hot result, held until the next accepted start
//   npairs  - number of 2-bit pairs examined for the held result
//
// All outputs come straight from flops. busy and done are derived from the
// next state so that they line up with the state register.
// -----------------------------------------------------------------------------
module cmp_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH / 2) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic          busy,
    output logic          done,
    output logic          gt,
    output logic          eq,
    output logic          lt,
    output logic [CW-1:0] npairs
);

    localparam int NPAIRS = WIDTH / 2;
    localparam int IW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  op_a_reg, op_a_next;
    logic [WIDTH-1:0]  op_b_reg, op_b_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic              gt_reg, gt_next;
    logic              eq_reg, eq_next;
    logic              lt_reg, lt_next;
    logic [CW-1:0]     npairs_reg, npairs_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;

    // Split the captured operands into 2-bit pairs. idx selects the pair that
    // is fed to the shared slice.
    logic [1:0] pair_a [NPAIRS];
    logic [1:0] pair_b [NPAIRS];

    genvar gi;
    generate
        for (gi = 0; gi < NPAIRS; gi++) begin : g_pairs
            assign pair_a[gi] = op_a_reg[2*gi +: 2];
            assign pair_b[gi] = op_b_reg[2*gi +: 2];
        end
    endgenerate

    // The single 2-bit comparator slice.
    logic [1:0] slice_a;
    logic [1:0] slice_b;
    logic       slice_gt;
    logic       slice_lt;

    assign slice_a  = pair_a[idx_reg];
    assign slice_b  = pair_b[idx_reg];
    assign slice_gt = (slice_a > slice_b);
    assign slice_lt = (slice_a < slice_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            idx_reg    <= '0;
            gt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
            lt_reg     <= 1'b0;
            npairs_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_a_reg   <= op_a_next;
            op_b_reg   <= op_b_next;
            idx_reg    <= idx_next;
            gt_reg     <= gt_next;
            eq_reg     <= eq_next;
            lt_reg     <= lt_next;
            npairs_reg <= npairs_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        op_a_next   = op_a_reg;
        op_b_next   = op_b_reg;
        idx_next    = idx_reg;
        gt_next     = gt_reg;
        eq_next     = eq_reg;
        lt_next     = lt_reg;
        npairs_next = npairs_reg;

        case (state_reg)
            // DONE accepts a start exactly like IDLE, so back-to-back
            // compares overlap the done cycle with the next capture.
            IDLE, DONE: begin
                if (start) begin
                    op_a_next   = A;
                    op_b_next   = B;
                    idx_next    = IW'(NPAIRS - 1);
                    gt_next     = 1'b0;
                    eq_next     = 1'b0;
                    lt_next     = 1'b0;
                    npairs_next = '0;
                    state_next  = SCAN;
                end else begin
                    state_next  = IDLE;
                end
            end
            SCAN: begin
                npairs_next = npairs_reg + CW'(1);
                if (slice_gt) begin
                    gt_next    = 1'b1;
                    state_next = DONE;
                end else if (slice_lt) begin
                    lt_next    = 1'b1;
                    state_next = DONE;
                end else if (idx_reg == '0) begin
                    eq_next    = 1'b1;
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg - IW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == SCAN);
        done_next = (state_next == DONE);
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign gt     = gt_reg;
    assign eq     = eq_reg;
    assign lt     = lt_reg;
    assign npairs = npairs_reg;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cmp_seq_ctrl
//
// Bench for cmp_seq_ctrl at WIDTH=8. The driver issues directed compares and
// pushes hand-computed results into a queue. The monitor pops one entry on
// every done pulse and checks flags, npairs and the edge on which done rose.
// -----------------------------------------------------------------------------
module tb_cmp_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH / 2) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             busy, done, gt, eq, lt;
    logic [CW-1:0]    npairs;

    cmp_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .gt     (gt),
        .eq     (eq),
        .lt     (lt),
        .npairs (npairs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] flags;   // {gt,eq,lt}
        int         np;
        int         e0;      // cycle index of the accepted-start edge
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   pushed  = 0;
    int   dones   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn A=%02h B=%02h gt=%0b eq=%0b lt=%0b npairs=%0d latency=%0d",
                             e.a, e.b, gt, eq, lt, npairs, cyc - e.e0 + 1);
                    chk("flags", int'({gt, eq, lt}), int'(e.flags));
                    chk("npairs", int'(npairs), e.np);
                    chk("latency", cyc - e.e0 + 1, e.np + 1);
                    chk("busy_in_done", int'(busy), 0);
                end
            end
        end
    end

    // Checks made right after an accepted-start edge, then the push.
    task automatic accept_and_push(input logic [7:0] a, input logic [7:0] b,
                                   input logic [2:0] flags, input int np);
        exp_t e;
        @(posedge clk);
        #1;
        chk("busy_after_start", int'(busy), 1);
        chk("flags_cleared", int'({gt, eq, lt}), 0);
        e.a = a; e.b = b; e.flags = flags; e.np = np; e.e0 = cyc;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() != 0) begin
            chk("timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run_cmp(input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] flags, input int np);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        accept_and_push(a, b, flags, np);
        @(negedge clk);
        start = 1'b0; A = 8'($urandom); B = 8'($urandom);
        wait_drain();
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", int'({busy, done, gt, eq, lt, npairs}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_outputs", int'({busy, done, gt, eq, lt, npairs}), 0);

        // MSB pair differs, equal operands, LSB pair differs, then gt.
        run_cmp(8'hA5, 8'h25, 3'b100, 1);
        chk("held_gt", int'({gt, eq, lt}), 4);
        chk("held_np", int'(npairs), 1);
        run_cmp(8'h3C, 8'h3C, 3'b010, 4);
        run_cmp(8'h12, 8'h13, 3'b001, 4);
        run_cmp(8'h40, 8'h00, 3'b100, 1);

        // Start pulse during SCAN must be ignored.
        @(negedge clk);
        start = 1'b1; A = 8'h00; B = 8'h00;
        accept_and_push(8'h00, 8'h00, 3'b010, 4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 8'hFF; B = 8'h00;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (8) @(posedge clk);
        #1;
        chk("ignored_start_idle", int'(busy), 0);

        // Back-to-back with start held high: gt after one pair each time.
        @(negedge clk);
        start = 1'b1; A = 8'hC0; B = 8'h80;
        for (int i = 0; i < 3; i++) begin
            accept_and_push(8'hC0, 8'h80, 3'b100, 1);
            if (i == 2) start = 1'b0;
            @(posedge clk);
        end
        wait_drain();

        // Reset in the 2nd SCAN cycle abandons the compare.
        @(negedge clk);
        start = 1'b1; A = 8'h3C; B = 8'h3C;
        @(posedge clk);
        #1;
        chk("rst_case_busy", int'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_scan_rst", int'({busy, done, gt, eq, lt, npairs}), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("after_abort_idle", int'({busy, done}), 0);
        run_cmp(8'h01, 8'h02, 3'b001, 4);

        repeat (4) @(posedge clk);
        #2;
        chk("done_count", dones, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
